// File: rtl/fpmulti_issue_ctrl_if.sv
// Bus between the issue controller, its operand producer, the external
// multiplier and the result consumer.
interface fpmulti_issue_ctrl_if;
   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // valid must not depend on ready, and offered data is held until taken.
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_A;
   logic [31:0] in_B;
   logic [31:0] reg_A;
   logic [31:0] reg_B;
   logic [31:0] mul_out;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic        busy;
   logic [15:0] done_cnt;

   modport slave (
      input  in_valid, in_A, in_B, mul_out, res_ready,
      output in_ready, reg_A, reg_B, res_valid, res_data, busy, done_cnt
   );

   modport master (
      output in_valid, in_A, in_B, mul_out, res_ready,
      input  in_ready, reg_A, reg_B, res_valid, res_data, busy, done_cnt
   );
endinterface

// File: rtl/fpmulti_issue_ctrl.sv
// Issue controller for a fixed-latency FP multiplier: operand FIFO, credit-based
// issue into a LATENCY-deep valid pipe, and an in-order result FIFO.
module fpmulti_issue_ctrl #(
   parameter int DEPTH   = 4,
   parameter int LATENCY = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   fpmulti_issue_ctrl_if.slave  bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // Counters are sized to hold inflight + result occupancy without overflow.
   localparam int CW = $clog2(DEPTH + LATENCY + 1) + 1;
   typedef logic [CW-1:0] cnt_t;

   logic [63:0]        op_mem  [DEPTH];
   logic [31:0]        res_mem [DEPTH];
   logic [PW-1:0]      op_wr_q, op_wr_d, op_rd_q, op_rd_d;
   logic [PW-1:0]      res_wr_q, res_wr_d, res_rd_q, res_rd_d;
   cnt_t               op_cnt_q, op_cnt_d, res_cnt_q, res_cnt_d, infl_q, infl_d;
   logic [LATENCY-1:0] pipe_q, pipe_d;
   logic [LATENCY:0]   pipe_ext;
   logic [31:0]        reg_a_q, reg_a_d, reg_b_q, reg_b_d;
   logic [15:0]        done_q, done_d;
   logic               in_ready, push, issue, capture, res_valid, pop;

   assign in_ready  = !reset && (op_cnt_q != cnt_t'(DEPTH));
   assign push      = bus.in_valid && in_ready;
   // Credit uses pre-edge counts only: a pop frees a slot for the next edge.
   assign issue     = (op_cnt_q != '0) && ((infl_q + res_cnt_q) < cnt_t'(DEPTH));
   assign capture   = pipe_q[LATENCY-1];
   assign res_valid = (res_cnt_q != '0);
   assign pop       = res_valid && bus.res_ready;
   assign pipe_ext  = {pipe_q, issue};

   always_comb begin
      op_wr_d   = op_wr_q + PW'(push);
      op_rd_d   = op_rd_q + PW'(issue);
      op_cnt_d  = op_cnt_q + cnt_t'(push) - cnt_t'(issue);
      res_wr_d  = res_wr_q + PW'(capture);
      res_rd_d  = res_rd_q + PW'(pop);
      res_cnt_d = res_cnt_q + cnt_t'(capture) - cnt_t'(pop);
      infl_d    = infl_q + cnt_t'(issue) - cnt_t'(capture);
      pipe_d    = pipe_ext[LATENCY-1:0];
      reg_a_d   = reg_a_q;
      reg_b_d   = reg_b_q;
      if (issue) begin
         reg_a_d = op_mem[op_rd_q][63:32];
         reg_b_d = op_mem[op_rd_q][31:0];
      end
      done_d    = done_q + 16'(pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_wr_q   <= '0;
         op_rd_q   <= '0;
         op_cnt_q  <= '0;
         res_wr_q  <= '0;
         res_rd_q  <= '0;
         res_cnt_q <= '0;
         infl_q    <= '0;
         pipe_q    <= '0;
         reg_a_q   <= '0;
         reg_b_q   <= '0;
         done_q    <= '0;
      end else begin
         op_wr_q   <= op_wr_d;
         op_rd_q   <= op_rd_d;
         op_cnt_q  <= op_cnt_d;
         res_wr_q  <= res_wr_d;
         res_rd_q  <= res_rd_d;
         res_cnt_q <= res_cnt_d;
         infl_q    <= infl_d;
         pipe_q    <= pipe_d;
         reg_a_q   <= reg_a_d;
         reg_b_q   <= reg_b_d;
         done_q    <= done_d;
      end
   end

   // Storage needs no reset: occupancy and pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push)    op_mem[op_wr_q]   <= {bus.in_A, bus.in_B};
      if (capture) res_mem[res_wr_q] <= bus.mul_out;
   end

   assign bus.in_ready  = in_ready;
   assign bus.reg_A     = reg_a_q;
   assign bus.reg_B     = reg_b_q;
   assign bus.res_valid = res_valid;
   assign bus.res_data  = res_valid ? res_mem[res_rd_q] : 32'h0;
   assign bus.busy      = (op_cnt_q != '0) || (infl_q != '0) || res_valid;
   assign bus.done_cnt  = done_q;
endmodule

// File: tb/tb_fpmulti_issue_ctrl.sv
// Randomised and directed bench for fpmulti_issue_ctrl against an in-order
// queue model, with a one-register-stage multiplier model on mul_out.
module tb_fpmulti_issue_ctrl;
   localparam int DEPTH = 4;
   localparam int LAT   = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fpmulti_issue_ctrl_if bus();
   fpmulti_issue_ctrl #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];
   int          pop_cyc[$];
   logic [15:0] done_model;
   logic [31:0] cur_exp;
   int          cyc     = 0;
   int          acc_cnt = 0;

   logic [31:0] vec_a[8] = '{32'h3FC00000, 32'hBF800000, 32'h00000000, 32'h40400000,
                             32'h3F000000, 32'h40000000, 32'hC0000000, 32'h3F800000};
   logic [31:0] vec_b[8] = '{32'h40000000, 32'h40800000, 32'h42280000, 32'h40000000,
                             32'h3F000000, 32'h40000000, 32'hC0400000, 32'h3F800000};
   logic [31:0] vec_e[8] = '{32'h40400000, 32'hC0800000, 32'h00000000, 32'h40C00000,
                             32'h3E800000, 32'h40800000, 32'h40C00000, 32'h3F800000};

   // Truncating single-precision multiply for normal operands and zeros.
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic [47:0] p;
      logic        s;
      int          e;
      s = a[31] ^ b[31];
      if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
      p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (p[47]) return {s, 8'(e + 1), p[46:24]};
      return {s, 8'(e), p[45:23]};
   endfunction

   logic [31:0] mul_q;
   always @(posedge clk) mul_q <= fmul(bus.reg_A, bus.reg_B);
   assign bus.mul_out = mul_q;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rand_fp();
      if ($urandom_range(0, 15) == 0) return 32'h0;
      return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
   endfunction

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e);
      bus.in_valid = v;
      bus.in_A     = a;
      bus.in_B     = b;
      cur_exp      = e;
   endtask

   task automatic drive_rand(input logic v);
      logic [31:0] a, b;
      a = rand_fp();
      b = rand_fp();
      drive(v, a, b, fmul(a, b));
   endtask

   // One clock: account for handshakes seen before the edge, then check after it.
   task automatic cycle();
      logic        pushed, popped, held;
      logic [31:0] data;
      pushed = !reset && bus.in_valid && bus.in_ready;
      popped = !reset && bus.res_valid && bus.res_ready;
      held   = !reset && bus.res_valid && !bus.res_ready;
      data   = bus.res_data;
      if (pushed) begin
         exp_q.push_back(cur_exp);
         acc_cnt++;
      end
      if (popped) begin
         if (exp_q.size() == 0) check("res_extra_pop", 32'(exp_q.size()), 32'd1);
         else check("res_data", data, exp_q.pop_front());
         done_model++;
         pop_cyc.push_back(cyc);
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (reset) begin
         exp_q.delete();
         done_model = 16'd0;
         check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      end
      check("busy", 32'(bus.busy), 32'(exp_q.size() != 0));
      check("done_cnt", 32'(bus.done_cnt), 32'(done_model));
      if (held && !reset) check("res_hold", bus.res_data, data);
   endtask

   task automatic drain();
      int n;
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      bus.res_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         cycle();
         n++;
      end
      check("drain_left", 32'(exp_q.size()), 32'd0);
      repeat (LAT + 2) cycle();
   endtask

   initial begin
      int n;
      int acc0;
      reset         = 1'b1;
      bus.res_ready = 1'b0;
      done_model    = 16'd0;
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      cycle();
      cycle();
      check("rst_res_valid", 32'(bus.res_valid), 32'd0);
      check("rst_res_data", bus.res_data, 32'h0);
      check("rst_reg_a", bus.reg_A, 32'h0);
      check("rst_reg_b", bus.reg_B, 32'h0);
      reset = 1'b0;
      cycle();
      check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

      // Single operation 3.0 * 2.0
      drive(1'b1, 32'h40400000, 32'h40000000, 32'h40C00000);
      cycle();
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      n = 0;
      while (!bus.res_valid && n < 20) begin
         cycle();
         n++;
      end
      check("single_latency", 32'(n), 32'(LAT + 1));
      check("single_res", bus.res_data, 32'h40C00000);
      check("single_reg_a", bus.reg_A, 32'h40400000);
      check("single_reg_b", bus.reg_B, 32'h40000000);
      bus.res_ready = 1'b1;
      cycle();
      bus.res_ready = 1'b0;
      check("single_done", 32'(bus.done_cnt), 32'd1);

      // Back-to-back directed vectors at full rate
      pop_cyc.delete();
      bus.res_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, vec_a[i], vec_b[i], vec_e[i]);
         cycle();
      end
      drain();
      check("b2b_count", 32'(pop_cyc.size()), 32'd8);
      if (pop_cyc.size() == 8) check("b2b_spacing", 32'(pop_cyc[7] - pop_cyc[0]), 32'd7);

      // Backpressure: issue stalls at DEPTH outstanding, then operand FIFO fills
      bus.res_ready = 1'b0;
      acc0 = acc_cnt;
      for (int i = 0; i < 3 * DEPTH; i++) begin
         drive_rand(1'b1);
         cycle();
      end
      check("bp_accepted", 32'(acc_cnt - acc0), 32'(2 * DEPTH));
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_res_valid", 32'(bus.res_valid), 32'd1);
      // One pop frees credit; the issue it enables lands on the next edge
      bus.res_ready = 1'b1;
      cycle();
      bus.res_ready = 1'b0;
      check("sim_in_ready_pre", 32'(bus.in_ready), 32'd0);
      cycle();
      check("sim_in_ready_post", 32'(bus.in_ready), 32'd1);
      check("sim_no_push", 32'(acc_cnt - acc0), 32'(2 * DEPTH));
      drain();

      // Random traffic with random backpressure
      for (int i = 0; i < 1500; i++) begin
         drive_rand(1'($urandom_range(0, 3) != 0));
         bus.res_ready = ($urandom_range(0, 2) != 0);
         cycle();
      end
      drain();

      // Reset with two products in flight and two results queued
      bus.res_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_rand(1'b1);
         cycle();
      end
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      cycle();
      check("mrst_pre_valid", 32'(bus.res_valid), 32'd1);
      reset = 1'b1;
      cycle();
      check("mrst_res_valid", 32'(bus.res_valid), 32'd0);
      check("mrst_res_data", bus.res_data, 32'h0);
      check("mrst_reg_a", bus.reg_A, 32'h0);
      reset = 1'b0;
      bus.res_ready = 1'b1;
      cycle();
      check("mrst_in_ready", 32'(bus.in_ready), 32'd1);
      for (int i = 0; i < 8; i++) begin
         cycle();
         check("mrst_no_stale", 32'(bus.res_valid), 32'd0);
      end

      // done_cnt wrap after 65536 pops
      bus.res_ready = 1'b1;
      n = 0;
      while (done_model != 16'hFFFF && n < 70000) begin
         drive_rand(1'b1);
         cycle();
         n++;
      end
      check("wrap_ffff", 32'(bus.done_cnt), 32'h0000FFFF);
      drive(1'b0, 32'h0, 32'h0, 32'h0);
      n = 0;
      while (done_model != 16'h0000 && n < 20) begin
         cycle();
         n++;
      end
      check("wrap_zero", 32'(bus.done_cnt), 32'h0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
